csi2_frame_scheduler: RTL and testbench

//  Frame/line timing master for the CSI-2 test-screen path: generates line_number/hori_pixel_count

---
 rtl/csi2_frame_scheduler.sv | 167 ++++++++++++++++
 tb/tb_csi2_frame_scheduler.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : csi2_frame_scheduler
// Description : CSI-2 test-screen frame/line timing master. It sequences the
//               FS/FE short-packet requests and paces the active words
//               against TX back-pressure.
//               Optional macro CSI2_FRAME_NUMBER_EN puts a wrapping frame
//               number into the short-packet data field.
// Revision    : 1.0 - initial release
// ============================================================================
module csi2_frame_scheduler #(
  parameter int H_ACTIVE = 400,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 100,
  parameter int V_BLANK  = 20,
  parameter int FNUM_MAX = 2
) (
  input  logic        byte_clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  output logic [11:0] line_number_o,
  output logic [11:0] hori_pixel_count_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic        sp_req_o,
  output logic [5:0]  sp_type_o,
  output logic [15:0] sp_data_o,
  input  logic        sp_ack_i,
  output logic [15:0] frame_count_o,
  output logic        busy_o
);

  localparam int c_BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int c_BW        = (c_BLANK_MAX > 1) ? $clog2(c_BLANK_MAX) : 1;

  localparam logic [c_BW-1:0] c_HB_LAST = c_BW'(H_BLANK - 1);
  localparam logic [c_BW-1:0] c_VB_LAST = c_BW'(V_BLANK - 1);
  localparam logic [11:0]     c_H_LAST  = 12'(H_ACTIVE - 1);
  localparam logic [11:0]     c_V_LINES = 12'(V_ACTIVE);

  localparam logic [2:0] c_S_IDLE        = 3'd0;
  localparam logic [2:0] c_S_FS_REQ      = 3'd1;
  localparam logic [2:0] c_S_LINE_ACT    = 3'd2;
  localparam logic [2:0] c_S_LINE_BLANK  = 3'd3;
  localparam logic [2:0] c_S_FE_REQ      = 3'd4;
  localparam logic [2:0] c_S_FRAME_BLANK = 3'd5;

  localparam logic [5:0] c_DT_FS = 6'h00;
  localparam logic [5:0] c_DT_FE = 6'h01;

  if (H_ACTIVE < 1 || H_ACTIVE > 4095 || V_ACTIVE < 1 || V_ACTIVE > 4095 ||
      H_BLANK < 1 || V_BLANK < 1 || FNUM_MAX < 1) begin : g_param_check
    $error("csi2_frame_scheduler: parameter out of legal range");
  end

  logic [2:0]      r_state;
  logic [11:0]     r_line;
  logic [11:0]     r_count;
  logic [c_BW-1:0] r_blank;
  logic [15:0]     r_frame_cnt;

  logic w_xfer;
  logic w_last_word;
  logic w_fb_done;
  logic w_fs_entry;

  assign w_xfer      = (r_state == c_S_LINE_ACT) && data_ready_i;
  assign w_last_word = (r_count == c_H_LAST);
  assign w_fb_done   = (r_state == c_S_FRAME_BLANK) && (r_blank == c_VB_LAST);
  assign w_fs_entry  = enable_i && ((r_state == c_S_IDLE) || w_fb_done);

  always_ff @(posedge byte_clk_i) begin
    if (reset_i) begin
      r_state     <= c_S_IDLE;
      r_line      <= 12'd0;
      r_count     <= 12'd0;
      r_blank     <= '0;
      r_frame_cnt <= 16'd0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (enable_i) r_state <= c_S_FS_REQ;
        end
        c_S_FS_REQ: begin
          if (sp_ack_i) begin
            r_state <= c_S_LINE_ACT;
            r_line  <= 12'd1;
            r_count <= 12'd0;
          end
        end
        c_S_LINE_ACT: begin
          // Without ready the word is re-presented unchanged next cycle.
          if (w_xfer) begin
            if (w_last_word) begin
              r_state <= c_S_LINE_BLANK;
              r_blank <= '0;
            end else begin
              r_count <= r_count + 12'd1;
            end
          end
        end
        c_S_LINE_BLANK: begin
          if (r_blank == c_HB_LAST) begin
            r_count <= 12'd0;
            if (r_line < c_V_LINES) begin
              r_state <= c_S_LINE_ACT;
              r_line  <= r_line + 12'd1;
            end else begin
              r_state <= c_S_FE_REQ;
              r_line  <= 12'd0;
            end
          end else begin
            r_blank <= r_blank + 1'b1;
          end
        end
        c_S_FE_REQ: begin
          if (sp_ack_i) begin
            r_state     <= c_S_FRAME_BLANK;
            r_blank     <= '0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        c_S_FRAME_BLANK: begin
          if (r_blank == c_VB_LAST) begin
            r_state <= enable_i ? c_S_FS_REQ : c_S_IDLE;
          end else begin
            r_blank <= r_blank + 1'b1;
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  assign line_number_o      = r_line;
  assign hori_pixel_count_o = r_count;
  assign data_valid_o       = (r_state == c_S_LINE_ACT);
  assign line_start_o       = data_valid_o && (r_count == 12'd0);
  assign line_end_o         = data_valid_o && w_last_word;
  assign sp_req_o           = (r_state == c_S_FS_REQ) || (r_state == c_S_FE_REQ);
  assign sp_type_o          = (r_state == c_S_FE_REQ) ? c_DT_FE : c_DT_FS;
  assign frame_count_o      = r_frame_cnt;
  assign busy_o             = (r_state != c_S_IDLE);

`ifdef CSI2_FRAME_NUMBER_EN
  logic [15:0] r_fnum;

  // Number advances on FS entry so FS and FE of one frame share it.
  always_ff @(posedge byte_clk_i) begin
    if (reset_i) begin
      r_fnum <= 16'd0;
    end else if (w_fs_entry) begin
      r_fnum <= (r_fnum >= 16'(FNUM_MAX)) ? 16'd1 : r_fnum + 16'd1;
    end
  end

  assign sp_data_o = sp_req_o ? r_fnum : 16'h0000;
`else
  logic w_fs_entry_unused;
  assign w_fs_entry_unused = w_fs_entry;
  assign sp_data_o         = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csi2_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_csi2_frame_scheduler
// Description : Scoreboard bench for csi2_frame_scheduler (H4 V3 HB2 VB3 FN2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csi2_frame_scheduler;

  localparam int c_H  = 4;
  localparam int c_V  = 3;
  localparam int c_HB = 2;
  localparam int c_VB = 3;
  localparam int c_FN = 2;

  typedef struct packed {
    logic [11:0] line;
    logic [11:0] cnt;
    logic        ls;
    logic        le;
  } word_t;

  typedef struct packed {
    logic [5:0]  ty;
    logic [15:0] d;
  } sp_t;

  logic        clk;
  logic        reset_i;
  logic        enable_i;
  logic [11:0] line_number_o;
  logic [11:0] hori_pixel_count_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic        line_start_o;
  logic        line_end_o;
  logic        sp_req_o;
  logic [5:0]  sp_type_o;
  logic [15:0] sp_data_o;
  logic        sp_ack_i;
  logic [15:0] frame_count_o;
  logic        busy_o;

  int    checks;
  int    failures;
  bit    rand_ready;
  word_t sb_w[$];
  sp_t   sb_sp[$];

  csi2_frame_scheduler #(
    .H_ACTIVE(c_H), .V_ACTIVE(c_V), .H_BLANK(c_HB), .V_BLANK(c_VB), .FNUM_MAX(c_FN)
  ) dut (
    .byte_clk_i        (clk),
    .reset_i           (reset_i),
    .enable_i          (enable_i),
    .line_number_o     (line_number_o),
    .hori_pixel_count_o(hori_pixel_count_o),
    .data_valid_o      (data_valid_o),
    .data_ready_i      (data_ready_i),
    .line_start_o      (line_start_o),
    .line_end_o        (line_end_o),
    .sp_req_o          (sp_req_o),
    .sp_type_o         (sp_type_o),
    .sp_data_o         (sp_data_o),
    .sp_ack_i          (sp_ack_i),
    .frame_count_o     (frame_count_o),
    .busy_o            (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every word/short-packet handshake pops one entry.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (data_valid_o && data_ready_i) begin
        word_t act;
        word_t exp;
        act = '{line: line_number_o, cnt: hori_pixel_count_o, ls: line_start_o, le: line_end_o};
        checks++;
        if (sb_w.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected: got line=%0d cnt=%0d, required none", act.line, act.cnt);
        end else begin
          exp = sb_w.pop_front();
          if (act !== exp) begin
            failures++;
            $display("FAIL word: got line=%0d cnt=%0d ls=%0b le=%0b, required line=%0d cnt=%0d ls=%0b le=%0b",
                     act.line, act.cnt, act.ls, act.le, exp.line, exp.cnt, exp.ls, exp.le);
          end
        end
      end
      if (sp_req_o && sp_ack_i) begin
        sp_t sact;
        sp_t sexp;
        sact = '{ty: sp_type_o, d: sp_data_o};
        checks++;
        if (sb_sp.size() == 0) begin
          failures++;
          $display("FAIL sp_unexpected: got type=%0h data=%0h, required none", sact.ty, sact.d);
        end else begin
          sexp = sb_sp.pop_front();
          if (sact !== sexp) begin
            failures++;
            $display("FAIL sp: got type=%0h data=%0h, required type=%0h data=%0h",
                     sact.ty, sact.d, sexp.ty, sexp.d);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    if (rand_ready) data_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset;
    reset_i    = 1'b1;
    enable_i   = 1'b0;
    data_ready_i = 1'b0;
    sp_ack_i   = 1'b0;
    rand_ready = 1'b0;
    repeat (3) tick();
    reset_i = 1'b0;
    sb_w.delete();
    sb_sp.delete();
  endtask

  task automatic push_frame(input logic [15:0] fnum);
    logic [15:0] d;
`ifdef CSI2_FRAME_NUMBER_EN
    d = fnum;
`else
    d = 16'h0000;
`endif
    sb_sp.push_back('{ty: 6'h00, d: d});
    for (int l = 1; l <= c_V; l++)
      for (int c = 0; c < c_H; c++)
        sb_w.push_back('{line: 12'(l), cnt: 12'(c), ls: (c == 0), le: (c == c_H - 1)});
    sb_sp.push_back('{ty: 6'h01, d: d});
  endtask

  // Waits for a short-packet request, lets it sit dly cycles, then acks it.
  task automatic ack_sp(input int dly, input string tag);
    int n;
    n = 0;
    while (!sp_req_o && n < 500) begin tick(); n++; end
    checks++;
    if (!sp_req_o) begin
      failures++;
      $display("FAIL %s_timeout: got sp_req_o=0, required 1 within 500 cycles", tag);
    end
    repeat (dly) tick();
    sp_ack_i = 1'b1;
    tick();
    sp_ack_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 500) begin tick(); n++; end
    checks++;
    if (busy_o) begin
      failures++;
      $display("FAIL %s_idle_timeout: got busy_o=1, required 0", tag);
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (sb_w.size() != 0 || sb_sp.size() != 0) begin
      failures++;
      $display("FAIL %s_drained: got words=%0d sps=%0d left, required 0 0", tag, sb_w.size(), sb_sp.size());
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({line_number_o, hori_pixel_count_o, data_valid_o, line_start_o, line_end_o,
         sp_req_o, sp_type_o, sp_data_o, frame_count_o, busy_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got line=%0d cnt=%0d valid=%0b req=%0b fc=%0d busy=%0b, required all 0",
               line_number_o, hori_pixel_count_o, data_valid_o, sp_req_o, frame_count_o, busy_o);
    end
  endtask

  task automatic test_basic_frame;
    do_reset();
    push_frame(16'd1);
    enable_i = 1'b1;
    data_ready_i = 1'b1;
    tick();
    checks++;
    if (sp_req_o !== 1'b1 || sp_type_o !== 6'h00 || data_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_fs: got req=%0b type=%0h valid=%0b, required 1 00 0", sp_req_o, sp_type_o, data_valid_o);
    end
    tick();
    sp_ack_i = 1'b1;
    tick();
    sp_ack_i = 1'b0;
    checks++;
    if (data_valid_o !== 1'b1 || line_number_o !== 12'd1 || hori_pixel_count_o !== 12'd0 || sp_req_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_first_word: got valid=%0b line=%0d cnt=%0d req=%0b, required 1 1 0 0",
               data_valid_o, line_number_o, hori_pixel_count_o, sp_req_o);
    end
    for (int l = 1; l <= c_V; l++) begin
      for (int c = 0; c < c_H; c++) begin
        checks++;
        if (data_valid_o !== 1'b1 || line_number_o !== 12'(l) || hori_pixel_count_o !== 12'(c)) begin
          failures++;
          $display("FAIL basic_active: got valid=%0b line=%0d cnt=%0d, required 1 %0d %0d",
                   data_valid_o, line_number_o, hori_pixel_count_o, l, c);
        end
        tick();
      end
      for (int b = 0; b < c_HB; b++) begin
        checks++;
        if (data_valid_o !== 1'b0 || line_number_o !== 12'(l)) begin
          failures++;
          $display("FAIL basic_hblank: got valid=%0b line=%0d, required 0 %0d", data_valid_o, line_number_o, l);
        end
        tick();
      end
    end
    checks++;
    if (sp_req_o !== 1'b1 || sp_type_o !== 6'h01 || line_number_o !== 12'd0) begin
      failures++;
      $display("FAIL basic_fe: got req=%0b type=%0h line=%0d, required 1 01 0", sp_req_o, sp_type_o, line_number_o);
    end
    tick();
    sp_ack_i = 1'b1;
    tick();
    sp_ack_i = 1'b0;
    checks++;
    if (frame_count_o !== 16'd1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_frame_count: got fc=%0d busy=%0b, required 1 1", frame_count_o, busy_o);
    end
    for (int b = 0; b < c_VB; b++) begin
      checks++;
      if (sp_req_o !== 1'b0) begin
        failures++;
        $display("FAIL basic_vblank: got sp_req_o=1 at blank cycle %0d, required 0", b);
      end
      tick();
    end
    checks++;
    if (sp_req_o !== 1'b1 || sp_type_o !== 6'h00) begin
      failures++;
      $display("FAIL basic_next_fs: got req=%0b type=%0h, required 1 00", sp_req_o, sp_type_o);
    end
    check_drained("basic");
  endtask

  task automatic test_backpressure;
    int n;
    do_reset();
    push_frame(16'd1);
    enable_i = 1'b1;
    data_ready_i = 1'b1;
    ack_sp(0, "bp_fs");
    n = 0;
    while (!(data_valid_o && line_number_o == 12'd2 && hori_pixel_count_o == 12'd2) && n < 200) begin
      tick(); n++;
    end
    data_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (data_valid_o !== 1'b1 || line_number_o !== 12'd2 || hori_pixel_count_o !== 12'd2) begin
        failures++;
        $display("FAIL bp_frozen: got valid=%0b line=%0d cnt=%0d, required 1 2 2",
                 data_valid_o, line_number_o, hori_pixel_count_o);
      end
    end
    data_ready_i = 1'b1;
    tick();
    checks++;
    if (hori_pixel_count_o !== 12'd3 || line_end_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume: got cnt=%0d line_end=%0b, required 3 1", hori_pixel_count_o, line_end_o);
    end
    enable_i = 1'b0;
    ack_sp(0, "bp_fe");
    wait_idle("bp");
    check_drained("bp");
  endtask

  task automatic test_ack_delay;
    do_reset();
    push_frame(16'd1);
    enable_i = 1'b1;
    data_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (sp_req_o !== 1'b1 || sp_type_o !== 6'h00 || data_valid_o !== 1'b0 || sp_data_o !== sb_sp[0].d) begin
        failures++;
        $display("FAIL ackdly_hold: got req=%0b type=%0h data=%0h valid=%0b, required 1 00 %0h 0",
                 sp_req_o, sp_type_o, sp_data_o, data_valid_o, sb_sp[0].d);
      end
      tick();
    end
    sp_ack_i = 1'b1;
    tick();
    sp_ack_i = 1'b0;
    checks++;
    if (data_valid_o !== 1'b1 || sp_req_o !== 1'b0) begin
      failures++;
      $display("FAIL ackdly_start: got valid=%0b req=%0b, required 1 0", data_valid_o, sp_req_o);
    end
    enable_i = 1'b0;
    ack_sp(3, "ackdly_fe");
    wait_idle("ackdly");
    check_drained("ackdly");
  endtask

  task automatic test_enable_drop;
    int n;
    do_reset();
    push_frame(16'd1);
    enable_i = 1'b1;
    data_ready_i = 1'b1;
    ack_sp(1, "endrop_fs");
    n = 0;
    while (!(data_valid_o && line_number_o == 12'd2) && n < 200) begin tick(); n++; end
    enable_i = 1'b0;
    ack_sp(0, "endrop_fe");
    for (int b = 0; b < c_VB; b++) begin
      checks++;
      if (busy_o !== 1'b1) begin
        failures++;
        $display("FAIL endrop_vblank: got busy_o=0 at blank cycle %0d, required 1", b);
      end
      tick();
    end
    checks++;
    if (busy_o !== 1'b0 || frame_count_o !== 16'd1 || line_number_o !== 12'd0) begin
      failures++;
      $display("FAIL endrop_idle: got busy=%0b fc=%0d line=%0d, required 0 1 0", busy_o, frame_count_o, line_number_o);
    end
    repeat (5) tick();
    checks++;
    if (sp_req_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL endrop_stay_idle: got req=%0b busy=%0b, required 0 0", sp_req_o, busy_o);
    end
    check_drained("endrop");
  endtask

  task automatic test_reset_mid_frame;
    int n;
    do_reset();
    push_frame(16'd1);
    enable_i = 1'b1;
    data_ready_i = 1'b1;
    ack_sp(0, "midrst_fs");
    n = 0;
    while (!(data_valid_o && line_number_o == 12'd3 && hori_pixel_count_o == 12'd1) && n < 200) begin
      tick(); n++;
    end
    reset_i = 1'b1;
    tick();
    checks++;
    if ({line_number_o, hori_pixel_count_o, data_valid_o, line_start_o, line_end_o,
         sp_req_o, sp_type_o, sp_data_o, frame_count_o, busy_o} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got line=%0d cnt=%0d valid=%0b req=%0b fc=%0d busy=%0b, required all 0",
               line_number_o, hori_pixel_count_o, data_valid_o, sp_req_o, frame_count_o, busy_o);
    end
    checks++;
    if (sb_w.size() != 3) begin
      failures++;
      $display("FAIL midrst_words_left: got %0d, required 3", sb_w.size());
    end
    reset_i  = 1'b0;
    enable_i = 1'b0;
    sb_w.delete();
    sb_sp.delete();
    sp_ack_i = 1'b1;
    repeat (6) tick();
    sp_ack_i = 1'b0;
    checks++;
    if (sp_req_o !== 1'b0 || frame_count_o !== 16'd0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_fe: got req=%0b fc=%0d busy=%0b, required 0 0 0", sp_req_o, frame_count_o, busy_o);
    end
  endtask

  task automatic test_frame_numbers;
    logic [15:0] exp_d;
    int n;
    do_reset();
    enable_i   = 1'b1;
    rand_ready = 1'b1;
    for (int f = 1; f <= 3; f++) begin
`ifdef CSI2_FRAME_NUMBER_EN
      exp_d = 16'(((f - 1) % c_FN) + 1);
`else
      exp_d = 16'h0000;
`endif
      push_frame(16'(((f - 1) % c_FN) + 1));
      n = 0;
      while (!sp_req_o && n < 500) begin tick(); n++; end
      checks++;
      if (sp_req_o !== 1'b1 || sp_type_o !== 6'h00 || sp_data_o !== exp_d) begin
        failures++;
        $display("FAIL fnum_fs%0d: got req=%0b type=%0h data=%0h, required 1 00 %0h", f, sp_req_o, sp_type_o, sp_data_o, exp_d);
      end
      sp_ack_i = 1'b1;
      tick();
      sp_ack_i = 1'b0;
      if (f == 3) enable_i = 1'b0;
      n = 0;
      while (!sp_req_o && n < 500) begin tick(); n++; end
      checks++;
      if (sp_req_o !== 1'b1 || sp_type_o !== 6'h01 || sp_data_o !== exp_d) begin
        failures++;
        $display("FAIL fnum_fe%0d: got req=%0b type=%0h data=%0h, required 1 01 %0h", f, sp_req_o, sp_type_o, sp_data_o, exp_d);
      end
      sp_ack_i = 1'b1;
      tick();
      sp_ack_i = 1'b0;
    end
    rand_ready   = 1'b0;
    data_ready_i = 1'b1;
    wait_idle("fnum");
    checks++;
    if (frame_count_o !== 16'd3) begin
      failures++;
      $display("FAIL fnum_frame_count: got %0d, required 3", frame_count_o);
    end
    check_drained("fnum");
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rand_ready = 1'b0;
    reset_i    = 1'b1;
    enable_i   = 1'b0;
    data_ready_i = 1'b0;
    sp_ack_i   = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_ack_delay();
    test_enable_drop();
    test_reset_mid_frame();
    test_frame_numbers();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
